// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: default coin count and coin code constants.
// No ports. Optional feature macro used by importers: COIN_DEBOUNCE_EN.
package vend_pkg;

  localparam int unsigned NUM_COINS_DEFAULT = 3;
  localparam int unsigned CODE_W_DEFAULT    = $clog2(NUM_COINS_DEFAULT + 1);

  typedef logic [CODE_W_DEFAULT-1:0] coin_code_t;

  localparam coin_code_t CODE_NONE     = coin_code_t'(0);
  localparam coin_code_t CODE_SHILLING = coin_code_t'(1);
  localparam coin_code_t CODE_FLORIN   = coin_code_t'(2);
  localparam coin_code_t CODE_CROWN    = coin_code_t'(3);

endpackage

// File: rtl/coin_fifo.sv
// Small synchronous FIFO for queued coin codes.
// Ports: clk, rst_n (async active-low), push/wr_data, pop, rd_data_c (head, 0 when
// empty), full, empty, fill (occupancy). Pushes while full are accepted only
// when a pop happens in the same cycle; pops while empty are ignored.
module coin_fifo #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned FILL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              full,
  output logic              empty,
  output logic [FILL_W-1:0] fill
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [FILL_W-1:0] fill_nxt;

  // Occupancy update: push-only increments, pop-only decrements.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    fill_nxt = fill;
    case ({do_push, do_pop})
      2'b10:   fill_nxt = fill + FILL_W'(1);
      2'b01:   fill_nxt = fill - FILL_W'(1);
      default: fill_nxt = fill;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fill  <= fill_nxt;
      full  <= (fill_nxt == FILL_W'(DEPTH));
      empty <= (fill_nxt == '0);
    end
  end

  // Storage needs no reset; the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data_c = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/coin_event_encoder.sv
// Coin event encoder: synchronises raw coin-sensor lines, detects insertions as
// rising edges, priority-encodes them (lowest line wins, code = line+1) and queues
// the codes for a valid/ready consumer.
// Ports: clk, rst_n (async active-low), coins (raw async lines), code_valid/code
// (FIFO head), code_ready, collision/overflow (sticky), clear_flags, fill.
// Optional feature macro: COIN_DEBOUNCE_EN adds a per-line stability filter of
// DEBOUNCE_CYC cycles between the synchroniser and the edge detector.
module coin_event_encoder
  import vend_pkg::*;
#(
  parameter int unsigned NUM_COINS    = NUM_COINS_DEFAULT,
  parameter int unsigned CODE_W       = $clog2(NUM_COINS + 1),
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DEBOUNCE_CYC = 4,
  localparam int unsigned FILL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_COINS-1:0] coins,
  output logic                 code_valid,
  output logic [CODE_W-1:0]    code,
  input  logic                 code_ready,
  output logic                 collision,
  output logic                 overflow,
  input  logic                 clear_flags,
  output logic [FILL_W-1:0]    fill
);

  // Reject configurations the FIFO and filter cannot support.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DEBOUNCE_CYC == 0) begin : g_bad_cfg
    $error("coin_event_encoder: FIFO_DEPTH must be a power of two >= 2 and DEBOUNCE_CYC >= 1");
  end

  logic [NUM_COINS-1:0] sync1;
  logic [NUM_COINS-1:0] sync2;
  logic [NUM_COINS-1:0] hist;
  logic [NUM_COINS-1:0] level;
  logic [NUM_COINS-1:0] rise;
  logic [CODE_W-1:0]    win_code;
  logic                 multi;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CODE_W-1:0]    head;

  // Two-flop synchroniser plus edge-history flop per line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= coins;
      sync2 <= sync1;
      hist  <= level;
    end
  end

`ifdef COIN_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [NUM_COINS-1:0] filt;
  logic [CNT_W-1:0]     cnt [NUM_COINS];

  // Filtered level follows sync2 only after DEBOUNCE_CYC consecutive differing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      for (int i = 0; i < int'(NUM_COINS); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_COINS); i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  assign rise = level & ~hist;

  // Lowest-index edge wins; clearing the lowest set bit leaves others iff >=2 edges.
  always_comb begin
    win_code = '0;
    for (int i = int'(NUM_COINS) - 1; i >= 0; i--) begin
      if (rise[i]) win_code = CODE_W'(i + 1);
    end
    multi = |(rise & (rise - NUM_COINS'(1)));
    push  = |rise;
  end

  assign pop = code_valid & code_ready;

  coin_fifo #(
    .DATA_W (CODE_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wr_data   (win_code),
    .pop       (pop),
    .rd_data_c (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

  assign code_valid = ~fifo_empty;
  assign code       = head;

  // Sticky flags; a set event in the clearing cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      collision <= (collision & ~clear_flags) | multi;
      overflow  <= (overflow & ~clear_flags) | (push & fifo_full & ~pop);
    end
  end

endmodule

// File: tb/tb_coin_event_encoder.sv
// Self-checking bench for coin_event_encoder (default build, COIN_DEBOUNCE_EN undefined).
// A reference model predicts accepted codes into a scoreboard queue and tracks
// occupancy and sticky flags; a negedge monitor compares DUT outputs against it.
module tb_coin_event_encoder;
  import vend_pkg::*;

  localparam int unsigned NC    = 3;
  localparam int unsigned CW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] coins = '0;
  logic          code_ready = 1'b0;
  logic          clear_flags = 1'b0;
  logic          code_valid;
  logic [CW-1:0] code;
  logic          collision;
  logic          overflow;
  logic [FW-1:0] fill;

  coin_event_encoder #(
    .NUM_COINS    (NC),
    .CODE_W       (CW),
    .FIFO_DEPTH   (DEPTH),
    .DEBOUNCE_CYC (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coins       (coins),
    .code_valid  (code_valid),
    .code        (code),
    .code_ready  (code_ready),
    .collision   (collision),
    .overflow    (overflow),
    .clear_flags (clear_flags),
    .fill        (fill)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an insertion is a 0->1 change between consecutive clock
  // samples of coins; it reaches the queue two clocks after being sampled.
  logic [NC-1:0] prev_s, d0, d1, cur;
  int            fill_m;
  bit            coll_m, ovf_m;
  int            sb_q[$];
  int            code_m, n_m;
  bit            pop_m, found;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_s = '0;
      d0     = '0;
      d1     = '0;
      fill_m = 0;
      coll_m = 1'b0;
      ovf_m  = 1'b0;
      sb_q.delete();
    end else begin
      cur    = d1;
      d1     = d0;
      d0     = coins & ~prev_s;
      prev_s = coins;
      pop_m  = (fill_m > 0) && code_ready;
      n_m    = $countones(cur);
      code_m = 0;
      found  = 1'b0;
      for (int i = 0; i < int'(NC); i++) begin
        if (cur[i] && !found) begin
          code_m = i + 1;
          found  = 1'b1;
        end
      end
      coll_m = (coll_m && !clear_flags) || (n_m >= 2);
      if (n_m > 0 && fill_m == int'(DEPTH) && !pop_m) begin
        ovf_m = 1'b1;
      end else begin
        ovf_m = ovf_m && !clear_flags;
        if (n_m > 0) begin
          sb_q.push_back(code_m);
          fill_m++;
        end
      end
      if (pop_m) fill_m--;
    end
  end

  // Monitor: outputs sampled mid-cycle; a handshake pops the scoreboard.
  always @(negedge clk) begin
    check("valid", int'(code_valid), int'(fill_m != 0));
    check("fill", int'(fill), fill_m);
    check("collision", int'(collision), int'(coll_m));
    check("overflow", int'(overflow), int'(ovf_m));
    if (!code_valid) begin
      check("code_idle", int'(code), 0);
    end else if (sb_q.size() == 0) begin
      check("unexpected_valid", int'(code_valid), 0);
    end else if (code_ready) begin
      check("code_pop", int'(code), sb_q.pop_front());
    end else begin
      check("code_hold", int'(code), sb_q[0]);
    end
  end

  task automatic step(input logic [NC-1:0] c, input logic rdy, input logic clr);
    @(posedge clk);
    #2;
    coins       = c;
    code_ready  = rdy;
    clear_flags = clr;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step('0, rdy, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [NC-1:0] rc;
  int            rdy_pct;

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single pulse on line 1 with consumer ready.
    step(3'b010, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Simultaneous edges on lines 0 and 2, then clear the collision flag.
    step(3'b101, 1'b1, 1'b0);
    idle(5, 1'b1);
    step('0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Five pulses with consumer stalled: fifth is dropped; then drain.
    for (int i = 0; i < 5; i++) begin
      step(3'b001, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
    end
    idle(4, 1'b0);
    idle(8, 1'b1);
    step('0, 1'b1, 1'b1);

    // Fill to full, then push arriving exactly when the consumer starts popping.
    step(3'b001, 1'b0, 1'b0); step('0, 1'b0, 1'b0);
    step(3'b010, 1'b0, 1'b0); step('0, 1'b0, 1'b0);
    step(3'b100, 1'b0, 1'b0); step('0, 1'b0, 1'b0);
    step(3'b001, 1'b0, 1'b0); step('0, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(3'b010, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(NC'(1) << (i % 3), 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
    end
    idle(6, 1'b1);

    // Line 2 held high across a mid-queue reset yields one more event.
    step(3'b001, 1'b0, 1'b0); step('0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(3'b100, 1'b0, 1'b0);
    pulse_reset();
    for (int i = 0; i < 5; i++) step(3'b100, 1'b0, 1'b0);
    idle(8, 1'b1);

    // Randomised traffic with varying consumer throughput.
    rc = '0;
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rdy_pct = int'($urandom_range(10, 100));
      if ($urandom_range(0, 3) == 0) rc = NC'($urandom_range(0, 7));
      step(rc, ($urandom_range(1, 100) <= rdy_pct), ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 599) == 0) pulse_reset();
    end

    // Drain and confirm nothing is left pending.
    idle(12, 1'b1);
    check("drain_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
